// File: rtl/i4_arb_pkg.sv
// Shared widths and FSM state encoding for the i4 request arbiter.
// Pure declarations; no logic, no latency, no flow control.
package i4_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int AUX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;
endpackage

// File: rtl/i4_rr_pick.sv
// Round-robin pick: first set bit of pend searching upward from ptr, wrapping.
// Purely combinational, zero latency; no flow control.
module i4_rr_pick
  import i4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] pend,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] idx;

  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // 2-bit addition wraps naturally, giving the mod-4 search order.
      idx = ptr + ID_W'(k);
      if (!any && pend[idx]) begin
        any = 1'b1;
        id  = idx;
      end
    end
  end

endmodule

// File: rtl/i4_req_arbiter.sv
// Edge-captures four request lines and serialises them as round-robin offers.
// Offer valid one cycle after pend sets; held until out_ready, then one idle cycle.
module i4_req_arbiter
  import i4_arb_pkg::*;
#(
  parameter int MISS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [AUX_W-1:0]   aux,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ID_W-1:0]    out_id,
  output logic [AUX_W-1:0]   out_aux,
  output logic [NUM_REQ-1:0] pend,
  output logic [MISS_W-1:0]  miss_cnt
);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  req_q, req_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [AUX_W-1:0]    aux_q, aux_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  logic [NUM_REQ-1:0]  rise;
  logic [NUM_REQ-1:0]  acc_vec;
  logic [NUM_REQ-1:0]  miss_vec;
  logic                accept;
  logic                pick_any;
  logic [ID_W-1:0]     pick_id;

  i4_rr_pick u_pick (
    .pend (pend_q),
    .ptr  (ptr_q),
    .any  (pick_any),
    .id   (pick_id)
  );

  always_comb begin
    req_d   = req;
    rise    = req & ~req_q;
    accept  = (state_q == OFFER) && out_ready;
    acc_vec = '0;
    if (accept) acc_vec[id_q] = 1'b1;

    // A fresh rise on the line being accepted re-arms it instead of counting a miss.
    miss_vec = rise & pend_q & ~acc_vec;
    pend_d   = (pend_q & ~acc_vec) | rise;

    miss_d = miss_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (miss_vec[i] && (miss_d != {MISS_W{1'b1}})) miss_d = miss_d + MISS_W'(1);
    end

    state_d = state_q;
    id_d    = id_q;
    aux_d   = aux_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OFFER;
          id_d    = pick_id;
          aux_d   = aux;
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_d = IDLE;
          ptr_d   = id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      aux_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      aux_q   <= aux_d;
      miss_q  <= miss_d;
    end
  end

  assign out_valid = (state_q == OFFER);
  assign out_id    = id_q;
  assign out_aux   = aux_q;
  assign pend      = pend_q;
  assign miss_cnt  = miss_q;

endmodule
